t03_instr_fetcher: RTL and testbench

Instruction fetch controller that drives the request side of the instruction-memory interface and produces the instruction word and freeze control consumed by the instruction holder. It accepts a fetch address from the CPU control path and issues a single-beat read on the memory bus. While a read is outstanding it holds the freeze line high so the downstream stage keeps its last instruction. It also buffers one early fetch request so that back-to-back redirects are not lost.

---
 rtl/t03_fetch_pkg.sv | 19 +
 rtl/t03_fetch_pending.sv | 25 ++
 rtl/t03_instr_fetcher.sv | 161 ++++++++++++++++
 tb/tb_t03_instr_fetcher.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the t03 instruction fetch controller.
package t03_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] T03_NOP_INSTR = 32'h0000_0013;

  localparam int unsigned T03_TIMEOUT_CYCLES_DEF = 16;

  // Watchdog counter runs 0 .. cycles-1 while a request is outstanding.
  function automatic int unsigned t03_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/t03_fetch_pending.sv
// One-deep, last-wins fetch address buffer; a set in the same cycle as a consume keeps the new entry.
module t03_fetch_pending
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [31:0] set_addr,
    input  logic        consume,
    output logic        pend_v,
    output logic [31:0] pend_addr
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (set) begin
      pend_v    <= 1'b1;
      pend_addr <= set_addr;
    end else if (consume) begin
      pend_v    <= 1'b0;
    end
  end

endmodule

// File: rtl/t03_instr_fetcher.sv
// Instruction fetch controller: single-beat memory reads, freeze while outstanding, one buffered redirect.
// Optional watchdog compiled in with T03_FETCH_TIMEOUT_EN.
module t03_instr_fetcher
  import t03_fetch_pkg::*;
  #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = T03_TIMEOUT_CYCLES_DEF
  )
  (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_load,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction_out,
    output logic        freezeInstr,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_err
  );

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  fetch_state_t state, state_n;
  logic         boot_pend;
  logic         pend_v;
  logic [31:0]  pend_addr;
  logic         pend_set;
  logic         pend_consume;
  logic         launch;
  logic [31:0]  launch_addr;
  logic         publish;
  logic [31:0]  publish_data;
  logic         timeout;

  t03_fetch_pending u_pending (
    .clk       (clk),
    .rst       (rst),
    .set       (pend_set),
    .set_addr  (pc_next),
    .consume   (pend_consume),
    .pend_v    (pend_v),
    .pend_addr (pend_addr)
  );

`ifdef T03_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = t03_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // An ack on the final allowed cycle still wins over the timeout.
  assign timeout   = (state == REQ) && !mem_ack && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (launch) begin
        to_cnt <= '0;
      end else if (state == REQ) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign fetch_busy = (state == REQ) || pend_v;

  always_comb begin
    state_n      = state;
    launch       = 1'b0;
    launch_addr  = pend_addr;
    pend_set     = 1'b0;
    pend_consume = 1'b0;
    publish      = 1'b0;
    publish_data = mem_rdata;
    unique case (state)
      IDLE: begin
        // A fresh pc_load supersedes any older buffered redirect.
        if (pc_load) begin
          launch       = 1'b1;
          launch_addr  = pc_next;
          pend_consume = pend_v;
        end else if (pend_v) begin
          launch       = 1'b1;
          launch_addr  = pend_addr;
          pend_consume = 1'b1;
        end else if (boot_pend) begin
          launch       = 1'b1;
          launch_addr  = RESET_PC;
        end
        if (launch) begin
          state_n = REQ;
        end
      end
      REQ: begin
        pend_set = pc_load;
        if (mem_ack) begin
          publish      = 1'b1;
          publish_data = mem_rdata;
          state_n      = DONE;
        end else if (timeout) begin
          publish      = 1'b1;
          publish_data = T03_NOP_INSTR;
          state_n      = DONE;
        end
      end
      DONE: begin
        pend_set = pc_load;
        if (pend_v) begin
          launch       = 1'b1;
          launch_addr  = pend_addr;
          pend_consume = 1'b1;
          state_n      = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      boot_pend       <= 1'b1;
      mem_req         <= 1'b0;
      freezeInstr     <= 1'b0;
      mem_addr        <= RESET_PC;
      instruction_out <= T03_NOP_INSTR;
      instr_valid     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req     <= (state_n == REQ);
      freezeInstr <= (state_n == REQ);
      instr_valid <= publish;
      if (launch) begin
        boot_pend <= 1'b0;
        mem_addr  <= launch_addr;
      end
      if (publish) begin
        instruction_out <= publish_data;
      end
    end
  end

endmodule

// File: tb/tb_t03_instr_fetcher.sv
// Scoreboard bench for t03_instr_fetcher: directed fetches, a memory responder and a publish monitor.
module tb_t03_instr_fetcher;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] K   = 32'h00A0_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int H_REQ = 0, H_VALID = 1, H_BUSY = 2, H_FREEZE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_next = '0;
  logic        pc_load = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction_out;
  logic        freezeInstr;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;

  always #5 clk = ~clk;

  t03_instr_fetcher #(
    .RESET_PC       (RPC),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_next         (pc_next),
    .pc_load         (pc_load),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instruction_out (instruction_out),
    .freezeInstr     (freezeInstr),
    .instr_valid     (instr_valid),
    .fetch_busy      (fetch_busy),
    .fetch_err       (fetch_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    cmp_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: actual %h, required %h", name, act, exp_v);
    end
  endtask

  // Cycle index and per-cycle output history, sampled mid-cycle.
  int   cyc_n = 0;
  logic req_h    [0:1023];
  logic valid_h  [0:1023];
  logic busy_h   [0:1023];
  logic freeze_h [0:1023];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (cyc_n < 1024) begin
      req_h[cyc_n]    = mem_req;
      valid_h[cyc_n]  = instr_valid;
      busy_h[cyc_n]   = fetch_busy;
      freeze_h[cyc_n] = freezeInstr;
    end
  end

  function automatic logic [31:0] hist_bits(input int sel, input int start, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      case (sel)
        H_REQ:   v[i] = req_h[start + i];
        H_VALID: v[i] = valid_h[start + i];
        H_BUSY:  v[i] = busy_h[start + i];
        default: v[i] = freeze_h[start + i];
      endcase
    end
    return v;
  endfunction

  // Memory responder: data = address + K, ack on the ack_delay-th request cycle.
  int unsigned rcnt       = 0;
  int unsigned ack_delay  = 3;
  logic        ack_en     = 1'b1;
  logic        resp_ack   = 1'b0;
  logic [31:0] resp_data  = '0;
  logic        stray_ack  = 1'b0;
  logic [31:0] stray_data = 32'hDEAD_BEEF;

  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = stray_ack ? stray_data : resp_data;

  always @(posedge clk) begin
    #2;
    if (!mem_req) begin
      rcnt     = 0;
      resp_ack = 1'b0;
    end else begin
      rcnt++;
      resp_ack  = ack_en && (rcnt == ack_delay);
      resp_data = mem_addr + K;
    end
  end

  // Publish monitor: every instr_valid pulse must match the oldest expected fetch.
  logic [31:0] last_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (mem_req) last_addr = mem_addr;
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_publish: actual %h at addr %h, required no publish", instruction_out, last_addr);
      end else begin
        e = exp_q.pop_front();
        chk("publish_addr", last_addr, e.addr);
        chk("publish_data", instruction_out, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},  32'(mem_req), 32'd0);
    chk({tag, "_freeze"},   32'(freezeInstr), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, RPC);
    chk({tag, "_instr"},    instruction_out, NOP);
    chk({tag, "_valid"},    32'(instr_valid), 32'd0);
    chk({tag, "_busy"},     32'(fetch_busy), 32'd0);
    chk({tag, "_err"},      32'(fetch_err), 32'd0);
  endtask

  initial begin
    int s;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk_reset_outputs("rst");

    // Boot fetch at RESET_PC, ack on third request cycle.
    ack_en = 1'b1;
    ack_delay = 3;
    exp_q.push_back('{RPC, RPC + K});
    tick();
    rst = 1'b0;
    s = cyc_n;
    repeat (8) tick();
    chk("boot_req",    hist_bits(H_REQ, s, 6),    32'b001110);
    chk("boot_freeze", hist_bits(H_FREEZE, s, 6), 32'b001110);
    chk("boot_valid",  hist_bits(H_VALID, s, 6),  32'b010000);

    // Zero-wait fetch from IDLE.
    ack_delay = 1;
    exp_q.push_back('{32'h40, 32'h40 + K});
    tick();
    pc_load = 1'b1;
    pc_next = 32'h40;
    s = cyc_n;
    tick();
    pc_load = 1'b0;
    repeat (5) tick();
    chk("zw_req",    hist_bits(H_REQ, s, 4),    32'b0010);
    chk("zw_freeze", hist_bits(H_FREEZE, s, 4), 32'b0010);
    chk("zw_valid",  hist_bits(H_VALID, s, 4),  32'b0100);

    // Two redirects during a fetch: last one wins, one DONE gap.
    ack_delay = 4;
    exp_q.push_back('{32'h40, 32'h40 + K});
    exp_q.push_back('{32'hC0, 32'hC0 + K});
    tick();
    pc_load = 1'b1;
    pc_next = 32'h40;
    s = cyc_n;
    tick();
    pc_next = 32'h80;
    tick();
    pc_next = 32'hC0;
    tick();
    pc_load = 1'b0;
    repeat (12) tick();
    chk("redir_req",   hist_bits(H_REQ, s, 12),   32'h3DE);
    chk("redir_valid", hist_bits(H_VALID, s, 12), 32'h420);
    chk("redir_busy",  hist_bits(H_BUSY, s, 12),  32'h3FE);

    // pc_load coincident with mem_ack.
    ack_delay = 2;
    exp_q.push_back('{32'h200, 32'h200 + K});
    exp_q.push_back('{32'h300, 32'h300 + K});
    tick();
    pc_load = 1'b1;
    pc_next = 32'h200;
    s = cyc_n;
    tick();
    pc_load = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_next = 32'h300;
    tick();
    pc_load = 1'b0;
    repeat (6) tick();
    chk("coin_req",   hist_bits(H_REQ, s, 7),   32'h36);
    chk("coin_valid", hist_bits(H_VALID, s, 7), 32'h48);

    // Reset mid-request, stray ack afterwards, boot restarts.
    ack_en = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_next = 32'h500;
    s = cyc_n;
    tick();
    pc_load = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    stray_ack = 1'b1;
    ack_en = 1'b1;
    ack_delay = 1;
    exp_q.push_back('{RPC, RPC + K});
    tick();
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ignored", instruction_out, NOP);
    repeat (4) tick();
    chk("rst_req",   hist_bits(H_REQ, s + 3, 4),   32'b0100);
    chk("rst_valid", hist_bits(H_VALID, s + 3, 4), 32'b1000);

`ifdef T03_FETCH_TIMEOUT_EN
    // Timeout after 4 request cycles publishes NOP and sets sticky error.
    ack_en = 1'b0;
    exp_q.push_back('{32'h600, NOP});
    tick();
    pc_load = 1'b1;
    pc_next = 32'h600;
    s = cyc_n;
    tick();
    pc_load = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("to_err_set", 32'(fetch_err), 32'd1);
    chk("to_req",     hist_bits(H_REQ, s, 7),   32'h1E);
    chk("to_valid",   hist_bits(H_VALID, s, 7), 32'h20);
    ack_en = 1'b1;
    ack_delay = 1;
    exp_q.push_back('{32'h700, 32'h700 + K});
    tick();
    pc_load = 1'b1;
    pc_next = 32'h700;
    tick();
    pc_load = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("to_err_cleared", 32'(fetch_err), 32'd0);
    exp_q.push_back('{RPC, RPC + K});
    tick();
    rst = 1'b0;
    repeat (5) tick();
`else
    // Without the watchdog, an unacknowledged request waits indefinitely.
    ack_en = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_next = 32'h600;
    tick();
    pc_load = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("nto_req_held", 32'(mem_req), 32'd1);
    chk("nto_addr",     mem_addr, 32'h600);
    chk("nto_err",      32'(fetch_err), 32'd0);
    exp_q.push_back('{32'h600, 32'h600 + K});
    tick();
    ack_delay = rcnt + 1;
    ack_en = 1'b1;
    repeat (4) tick();
`endif

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
